// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: takes a byte over valid/ready and serialises it as
// start, LSB-first data, optional parity and 1-2 stop bits, one bit per tx_baud tick.
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  tx_baud,
  input  logic                  parity_en,
  input  logic                  parity_odd,
  input  logic                  two_stop,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic                  tx_out,
  output logic                  tx_busy,
  output logic                  tx_done
);

  typedef enum logic [2:0] {
    IDLE, ARMED, START, DATA, PARITY, STOP1, STOP2
  } state_e;

  localparam logic [2:0] LastIdx = 3'(DATA_WIDTH - 1);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [2:0]            idx_q, idx_d;
  logic                  parity_q, parity_d;
  logic                  parEn_q, parEn_d;
  logic                  twoStop_q, twoStop_d;
  logic                  txOut_q, txOut_d;
  logic                  txBusy_q, txBusy_d;
  logic                  txDone_q, txDone_d;

  assign data_ready = (state_q == IDLE);
  assign tx_out     = txOut_q;
  assign tx_busy    = txBusy_q;
  assign tx_done    = txDone_q;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    idx_d     = idx_q;
    parity_d  = parity_q;
    parEn_d   = parEn_q;
    twoStop_d = twoStop_q;
    txDone_d  = 1'b0;

    // Every transition except the IDLE handshake waits for a bit-period tick.
    case (state_q)
      IDLE: begin
        if (data_valid) begin
          shift_d   = data_in;
          parity_d  = (^data_in) ^ parity_odd;
          parEn_d   = parity_en;
          twoStop_d = two_stop;
          state_d   = ARMED;
        end
      end
      ARMED: begin
        if (tx_baud) state_d = START;
      end
      START: begin
        if (tx_baud) begin
          state_d = DATA;
          idx_d   = 3'd0;
        end
      end
      DATA: begin
        if (tx_baud) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 3'd1;
          if (idx_q == LastIdx) state_d = parEn_q ? PARITY : STOP1;
        end
      end
      PARITY: begin
        if (tx_baud) state_d = STOP1;
      end
      STOP1: begin
        if (tx_baud) begin
          if (twoStop_q) begin
            state_d = STOP2;
          end else begin
            state_d  = IDLE;
            txDone_d = 1'b1;
          end
        end
      end
      STOP2: begin
        if (tx_baud) begin
          state_d  = IDLE;
          txDone_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level is registered from the next state so it tracks state_q exactly.
    case (state_d)
      START:   txOut_d = 1'b0;
      DATA:    txOut_d = shift_d[0];
      PARITY:  txOut_d = parity_q;
      default: txOut_d = 1'b1;
    endcase
    txBusy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      idx_q     <= 3'd0;
      parity_q  <= 1'b0;
      parEn_q   <= 1'b0;
      twoStop_q <= 1'b0;
      txOut_q   <= 1'b1;
      txBusy_q  <= 1'b0;
      txDone_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      idx_q     <= idx_d;
      parity_q  <= parity_d;
      parEn_q   <= parEn_d;
      twoStop_q <= twoStop_d;
      txOut_q   <= txOut_d;
      txBusy_q  <= txBusy_d;
      txDone_q  <= txDone_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: frames are compared bit-by-bit against
// hand-written line sequences, sampling on the falling clock edge.
module tb_uart_tx_ctrl;

  localparam int P = 16;

  logic       clock = 1'b0;
  logic       reset;
  logic       tx_baud;
  logic       parity_en;
  logic       parity_odd;
  logic       two_stop;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       tx_out;
  logic       tx_busy;
  logic       tx_done;

  int compareCnt  = 0;
  int mismatchCnt = 0;
  int tickCnt;
  int highCnt;

  uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .tx_baud    (tx_baud),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .two_stop   (two_stop),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .tx_out     (tx_out),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done)
  );

  always #5 clock = ~clock;

  // Free-running baud tick: one clock high every P clocks.
  initial begin
    tx_baud = 1'b0;
    tickCnt = 0;
    forever begin
      @(posedge clock);
      #1;
      tickCnt = (tickCnt + 1) % P;
      tx_baud = (tickCnt == 0);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCnt++;
    if (observed !== expected) begin
      mismatchCnt++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic pe, input logic po,
                               input logic ts, input bit holdValid);
    int waitCnt;
    waitCnt = 0;
    while (data_ready !== 1'b1 && waitCnt < 20 * P) begin
      @(negedge clock);
      waitCnt++;
    end
    if (data_ready !== 1'b1) checkOutput("readyTimeout", data_ready, 1);
    data_in    = data;
    parity_en  = pe;
    parity_odd = po;
    two_stop   = ts;
    data_valid = 1'b1;
    @(posedge clock);
    #1;
    if (!holdValid) data_valid = 1'b0;
  endtask

  task automatic waitStart(input string tag, output int highs);
    int busyLow;
    highs   = 0;
    busyLow = 0;
    @(negedge clock);
    while (tx_out !== 1'b0 && highs < 4 * P) begin
      if (tx_busy !== 1'b1) busyLow++;
      highs++;
      @(negedge clock);
    end
    checkOutput({tag, "_armedBusyLow"}, busyLow, 0);
    if (tx_out !== 1'b0) checkOutput({tag, "_startTimeout"}, tx_out, 0);
  endtask

  task automatic checkFrame(input logic [11:0] expBits, input int len, input string tag,
                            input bit toggleCfg);
    int good;
    int busyLow;
    int doneSeen;
    busyLow  = 0;
    doneSeen = 0;
    for (int b = 0; b < len; b++) begin
      good = 0;
      for (int c = 0; c < P; c++) begin
        if (b > 0 || c > 0) @(negedge clock);
        if (tx_out === expBits[len-1-b]) good++;
        if (tx_busy !== 1'b1) busyLow++;
        if (tx_done !== 1'b0) doneSeen++;
        if (toggleCfg && b == 4 && c == 0) begin
          two_stop  = ~two_stop;
          parity_en = ~parity_en;
        end
      end
      checkOutput($sformatf("%s_bit%0d", tag, b), good, P);
    end
    checkOutput({tag, "_busyLow"}, busyLow, 0);
    checkOutput({tag, "_earlyDone"}, doneSeen, 0);
    @(negedge clock);
    checkOutput({tag, "_done"}, tx_done, 1);
    checkOutput({tag, "_readyAtDone"}, data_ready, 1);
    checkOutput({tag, "_idleLine"}, tx_out, 1);
  endtask

  task automatic watchIdle(input string tag, input int cycles);
    int lows;
    int dones;
    lows  = 0;
    dones = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      if (tx_out !== 1'b1) lows++;
      if (tx_done !== 1'b0) dones++;
    end
    checkOutput({tag, "_lineLow"}, lows, 0);
    checkOutput({tag, "_done"}, dones, 0);
  endtask

  initial begin
    int waitCnt;
    reset      = 1'b1;
    data_valid = 1'b0;
    data_in    = 8'h00;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    two_stop   = 1'b0;

    // Reset values must appear before any clock edge.
    #1;
    checkOutput("rst_txOut", tx_out, 1);
    checkOutput("rst_busy", tx_busy, 0);
    checkOutput("rst_ready", data_ready, 1);
    checkOutput("rst_done", tx_done, 0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    watchIdle("postReset", 3 * P);

    applyStimulus(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    waitStart("a5_8n1", highCnt);
    checkFrame(12'b0_10100101_1, 10, "a5_8n1", 1'b0);

    applyStimulus(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    waitStart("a5_8e1", highCnt);
    checkFrame(12'b0_10100101_0_1, 11, "a5_8e1", 1'b0);

    applyStimulus(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0);
    waitStart("a5_8o1", highCnt);
    checkFrame(12'b0_10100101_1_1, 11, "a5_8o1", 1'b0);

    applyStimulus(8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
    waitStart("x07_8e1", highCnt);
    checkFrame(12'b0_11100000_1_1, 11, "x07_8e1", 1'b0);

    applyStimulus(8'h07, 1'b1, 1'b1, 1'b0, 1'b0);
    waitStart("x07_8o1", highCnt);
    checkFrame(12'b0_11100000_0_1, 11, "x07_8o1", 1'b0);

    // Config flipped mid-frame must not alter a frame already latched.
    applyStimulus(8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
    waitStart("ff_8n2", highCnt);
    checkFrame(12'b0_11111111_1_1, 11, "ff_8n2", 1'b1);

    // Back-to-back with data_valid held; data_in changes while busy.
    applyStimulus(8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
    waitStart("b2b_first", highCnt);
    data_in = 8'h0F;
    checkFrame(12'b0_10101010_1, 10, "b2b_first", 1'b0);
    waitStart("b2b_second", highCnt);
    data_valid = 1'b0;
    checkOutput("b2b_gapClocks", highCnt, P - 1);
    checkFrame(12'b0_11110000_1, 10, "b2b_second", 1'b0);

    // Abort in the middle of data bit 3 of an all-zero byte.
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    waitStart("abort", highCnt);
    repeat (4 * P + P / 2) @(negedge clock);
    checkOutput("abort_preLine", tx_out, 0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("abort_txOut", tx_out, 1);
    checkOutput("abort_busy", tx_busy, 0);
    checkOutput("abort_ready", data_ready, 1);
    checkOutput("abort_done", tx_done, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    watchIdle("postAbort", 3 * P);
    applyStimulus(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    waitStart("afterAbort", highCnt);
    checkFrame(12'b0_10100101_1, 10, "afterAbort", 1'b0);

    // Transfer on an edge that also carries a tick.
    waitCnt = 0;
    while (!(tx_baud === 1'b1 && data_ready === 1'b1) && waitCnt < 4 * P) begin
      @(negedge clock);
      waitCnt++;
    end
    checkOutput("align_found", (tx_baud === 1'b1 && data_ready === 1'b1), 1);
    data_in    = 8'hA5;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    two_stop   = 1'b0;
    data_valid = 1'b1;
    @(posedge clock);
    #1;
    data_valid = 1'b0;
    waitStart("align", highCnt);
    checkOutput("align_armedClocks", highCnt, P);
    checkFrame(12'b0_10100101_1, 10, "align", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCnt, mismatchCnt);
    $finish;
  end

endmodule
